// File: rtl/avalon_s_crossbar_rr.sv
// Avalon-MM crossbar: NH hosts to ND address-windowed devices, per-device round-robin.
// Define AVN_XBAR_DECERR_EN to flag unmapped accesses on hosts_decerr with all-ones readdata.
module avalon_s_crossbar_rr #(
  parameter int NH = 2,
  parameter int ND = 2,
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NH-1:0]            hosts_avn_read,
  input  logic [NH-1:0]            hosts_avn_write,
  input  logic [NH-1:0][AW-1:0]    hosts_avn_address,
  input  logic [NH-1:0][DW/8-1:0]  hosts_avn_byte_enable,
  input  logic [NH-1:0][DW-1:0]    hosts_avn_writedata,
  output logic [NH-1:0][DW-1:0]    hosts_avn_readdata,
  output logic [NH-1:0]            hosts_avn_waitrequest,
  output logic [ND-1:0]            devices_avn_read,
  output logic [ND-1:0]            devices_avn_write,
  output logic [ND-1:0][AW-1:0]    devices_avn_address,
  output logic [ND-1:0][DW/8-1:0]  devices_avn_byte_enable,
  output logic [ND-1:0][DW-1:0]    devices_avn_writedata,
  input  logic [ND-1:0][DW-1:0]    devices_avn_readdata,
  input  logic [ND-1:0]            devices_avn_waitrequest,
  input  logic [ND-1:0][AW-1:0]    devices_address_low,
  input  logic [ND-1:0][AW-1:0]    devices_address_high,
  output logic [NH-1:0]            hosts_decerr
);

  localparam int HW  = (NH > 1) ? $clog2(NH) : 1;
  localparam int DIW = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic {IDLE, BUSY} st_t;

  st_t                  state_q [ND];
  st_t                  state_d [ND];
  logic [ND-1:0][HW-1:0] grant_q, grant_d;
  logic [ND-1:0][HW-1:0] last_q, last_d;

  logic [NH-1:0]          act;
  logic [NH-1:0]          mapped;
  logic [NH-1:0][DIW-1:0] tgt;
  logic [ND-1:0][NH-1:0]  req;
  logic                   live;
  logic [NH-1:0]          rest;

  // First requester strictly after start, wrapping back to start last.
  function automatic logic [HW-1:0] rr_pick(
    input logic [NH-1:0] r,
    input logic [HW-1:0] start
  );
    logic [HW-1:0] pick;
    int idx;
    pick = start;
    for (int off = NH; off >= 1; off--) begin
      idx = (int'(start) + off) % NH;
      if (r[idx]) pick = HW'(idx);
    end
    return pick;
  endfunction

  // Descending scan so the lowest matching window wins.
  always_comb begin
    act    = '0;
    mapped = '0;
    tgt    = '0;
    req    = '0;
    for (int h = 0; h < NH; h++) begin
      act[h] = hosts_avn_read[h] | hosts_avn_write[h];
      for (int d = ND - 1; d >= 0; d--) begin
        if (act[h] &&
            hosts_avn_address[h] >= devices_address_low[d] &&
            hosts_avn_address[h] <= devices_address_high[d]) begin
          mapped[h] = 1'b1;
          tgt[h]    = DIW'(d);
        end
      end
      for (int d = 0; d < ND; d++) begin
        if (mapped[h] && tgt[h] == DIW'(d)) req[d][h] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < ND; d++) state_q[d] <= IDLE;
      grant_q <= '0;
      last_q  <= {ND{HW'(NH - 1)}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    live    = 1'b0;
    rest    = '0;
    for (int d = 0; d < ND; d++) begin
      live = req[d][grant_q[d]];
      rest = req[d];
      rest[grant_q[d]] = 1'b0;
      unique case (state_q[d])
        IDLE: begin
          if (|req[d]) begin
            grant_d[d] = rr_pick(req[d], last_q[d]);
            state_d[d] = BUSY;
          end
        end
        BUSY: begin
          if (!live) begin
            state_d[d] = IDLE;
          end else if (!devices_avn_waitrequest[d]) begin
            last_d[d] = grant_q[d];
            if (|rest) grant_d[d] = rr_pick(rest, grant_q[d]);
            else       state_d[d] = IDLE;
          end
        end
        default: state_d[d] = IDLE;
      endcase
    end
  end

  always_comb begin
    devices_avn_read        = '0;
    devices_avn_write       = '0;
    devices_avn_address     = '0;
    devices_avn_byte_enable = '0;
    devices_avn_writedata   = '0;
    for (int d = 0; d < ND; d++) begin
      if (state_q[d] == BUSY && req[d][grant_q[d]]) begin
        devices_avn_write[d] = hosts_avn_write[grant_q[d]];
        devices_avn_read[d]  = hosts_avn_read[grant_q[d]] &
                               ~hosts_avn_write[grant_q[d]];
        devices_avn_address[d]     = hosts_avn_address[grant_q[d]];
        devices_avn_byte_enable[d] = hosts_avn_byte_enable[grant_q[d]];
        devices_avn_writedata[d]   = hosts_avn_writedata[grant_q[d]];
      end
    end
  end

  always_comb begin
    hosts_avn_waitrequest = '0;
    hosts_avn_readdata    = '0;
    hosts_decerr          = '0;
    for (int h = 0; h < NH; h++) begin
      if (act[h] && !mapped[h]) begin
`ifdef AVN_XBAR_DECERR_EN
        hosts_decerr[h]       = rst;
        hosts_avn_readdata[h] = '1;
`else
        hosts_decerr[h]       = 1'b0;
`endif
      end else if (mapped[h]) begin
        if (state_q[tgt[h]] == BUSY && grant_q[tgt[h]] == HW'(h)) begin
          hosts_avn_waitrequest[h] = devices_avn_waitrequest[tgt[h]];
          hosts_avn_readdata[h]    = devices_avn_readdata[tgt[h]];
        end else begin
          hosts_avn_waitrequest[h] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_s_crossbar_rr.sv
// Directed bench for avalon_s_crossbar_rr: 2 hosts, 2 devices.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
module tb_avalon_s_crossbar_rr;

  localparam int NH = 2;
  localparam int ND = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [NH-1:0]           h_rd, h_wr, h_wait, decerr;
  logic [NH-1:0][AW-1:0]   h_addr;
  logic [NH-1:0][DW/8-1:0] h_be;
  logic [NH-1:0][DW-1:0]   h_wd, h_rdata;
  logic [ND-1:0]           d_rd, d_wr, d_wait;
  logic [ND-1:0][AW-1:0]   d_addr, lo, hi;
  logic [ND-1:0][DW/8-1:0] d_be;
  logic [ND-1:0][DW-1:0]   d_wd, d_rdata;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  avalon_s_crossbar_rr #(.NH(NH), .ND(ND), .DW(DW), .AW(AW)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .hosts_avn_read          (h_rd),
    .hosts_avn_write         (h_wr),
    .hosts_avn_address       (h_addr),
    .hosts_avn_byte_enable   (h_be),
    .hosts_avn_writedata     (h_wd),
    .hosts_avn_readdata      (h_rdata),
    .hosts_avn_waitrequest   (h_wait),
    .devices_avn_read        (d_rd),
    .devices_avn_write       (d_wr),
    .devices_avn_address     (d_addr),
    .devices_avn_byte_enable (d_be),
    .devices_avn_writedata   (d_wd),
    .devices_avn_readdata    (d_rdata),
    .devices_avn_waitrequest (d_wait),
    .devices_address_low     (lo),
    .devices_address_high    (hi),
    .hosts_decerr            (decerr)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic hosts_idle();
    h_rd   = '0;
    h_wr   = '0;
    h_addr = '0;
    h_wd   = '0;
    h_be   = '0;
  endtask

  initial begin
    hosts_idle();
    d_wait  = '0;
    d_rdata = '0;
    lo[0] = 32'h0000; hi[0] = 32'h0FFF;
    lo[1] = 32'h1000; hi[1] = 32'h1FFF;

    // reset holds devices quiet even with a live request
    h_rd[0] = 1'b1; h_addr[0] = 32'h1000;
    repeat (2) tick();
    settle();
    check("rst_dev_rd", 64'(d_rd), 64'h0);
    check("rst_dev_wr", 64'(d_wr), 64'h0);
    check("rst_decerr", 64'(decerr), 64'h0);
    hosts_idle();
    tick();
    rst = 1'b1;

    // single read with two device wait cycles
    tick();
    h_rd[0] = 1'b1; h_addr[0] = 32'h1000;
    d_wait = 2'b10; d_rdata[1] = 32'hCAFEF00D;
    settle();
    check("a_c0_wait", 64'(h_wait[0]), 64'h1);
    check("a_c0_drd", 64'(d_rd), 64'h0);
    tick(); settle();
    check("a_c1_drd", 64'(d_rd), 64'h2);
    check("a_c1_addr", 64'(d_addr[1]), 64'h1000);
    check("a_c1_wait", 64'(h_wait[0]), 64'h1);
    tick(); settle();
    check("a_c2_wait", 64'(h_wait[0]), 64'h1);
    tick();
    d_wait = '0;
    settle();
    check("a_c3_wait", 64'(h_wait[0]), 64'h0);
    check("a_c3_rdata", 64'(h_rdata[0]), 64'hCAFEF00D);
    check("a_c3_dev0", 64'(d_rd[0]), 64'h0);
    tick();
    hosts_idle(); d_rdata = '0;
    settle();
    check("a_idle", 64'(d_rd), 64'h0);

    // reset while dev1 is busy, then host0 must win first
    tick();
    h_rd[0] = 1'b1; h_addr[0] = 32'h1004; d_wait = 2'b10;
    settle();
    tick(); settle();
    check("e_busy", 64'(d_rd[1]), 64'h1);
    #1 rst = 1'b0;
    #1;
    check("e_rst_rd", 64'(d_rd), 64'h0);
    check("e_rst_wait", 64'(h_wait[0]), 64'h1);
    hosts_idle();
    tick();
    rst = 1'b1;
    tick();
    h_rd = 2'b11; h_addr[0] = 32'h1008; h_addr[1] = 32'h100C; d_wait = '0;
    settle();
    check("e_c0_wait", 64'(h_wait), 64'h3);
    tick(); settle();
    check("e_first_addr", 64'(d_addr[1]), 64'h1008);
    check("e_first_wait", 64'(h_wait), 64'h2);
    tick();
    h_rd[0] = 1'b0;
    settle();
    check("e_second_addr", 64'(d_addr[1]), 64'h100C);
    check("e_second_wait", 64'(h_wait[1]), 64'h0);
    tick(); hosts_idle(); settle();

    // write contention on dev0
    tick();
    h_wr = 2'b11; h_be = '1;
    h_addr[0] = 32'h10; h_addr[1] = 32'h20;
    h_wd[0] = 32'hAAAA0000; h_wd[1] = 32'hBBBB1111;
    settle();
    check("b_c0_wait", 64'(h_wait), 64'h3);
    tick(); settle();
    check("b_c1_wd", 64'(d_wd[0]), 64'hAAAA0000);
    check("b_c1_wr", 64'(d_wr), 64'h1);
    check("b_c1_be", 64'(d_be[0]), 64'hF);
    check("b_c1_wait", 64'(h_wait), 64'h2);
    tick();
    h_wr[0] = 1'b0;
    settle();
    check("b_c2_wd", 64'(d_wd[0]), 64'hBBBB1111);
    check("b_c2_wait", 64'(h_wait), 64'h0);
    tick(); hosts_idle(); settle();
    // host0 alone, leaving host0 as last grant
    tick();
    h_wr[0] = 1'b1; h_addr[0] = 32'h30; h_wd[0] = 32'h12345678; h_be = '1;
    settle();
    tick(); settle();
    check("b_solo_wd", 64'(d_wd[0]), 64'h12345678);
    check("b_solo_wait", 64'(h_wait[0]), 64'h0);
    tick(); hosts_idle(); settle();
    // repeated contention now favours host1
    tick();
    h_wr = 2'b11; h_be = '1;
    h_addr[0] = 32'h10; h_addr[1] = 32'h20;
    h_wd[0] = 32'hAAAA0000; h_wd[1] = 32'hBBBB1111;
    settle();
    tick(); settle();
    check("b_rep_wd", 64'(d_wd[0]), 64'hBBBB1111);
    check("b_rep_wait", 64'(h_wait), 64'h1);
    tick();
    h_wr[1] = 1'b0;
    settle();
    check("b_rep2_wd", 64'(d_wd[0]), 64'hAAAA0000);
    check("b_rep2_wait", 64'(h_wait), 64'h0);
    tick(); hosts_idle(); settle();

    // parallel accesses to separate devices
    tick();
    h_wr = 2'b11; h_be = '1;
    h_addr[0] = 32'h100; h_addr[1] = 32'h1100;
    h_wd[0] = 32'h11111111; h_wd[1] = 32'h22222222;
    settle();
    check("c_c0_wait", 64'(h_wait), 64'h3);
    tick(); settle();
    check("c_wr", 64'(d_wr), 64'h3);
    check("c_wd0", 64'(d_wd[0]), 64'h11111111);
    check("c_wd1", 64'(d_wd[1]), 64'h22222222);
    check("c_wait", 64'(h_wait), 64'h0);
    tick(); hosts_idle(); settle();

    // unmapped read
    tick();
    h_rd[1] = 1'b1; h_addr[1] = 32'h8000;
    settle();
    check("d_wait", 64'(h_wait[1]), 64'h0);
    check("d_dev_rd", 64'(d_rd), 64'h0);
`ifdef AVN_XBAR_DECERR_EN
    check("d_decerr", 64'(decerr), 64'h2);
    check("d_rdata", 64'(h_rdata[1]), 64'hFFFFFFFF);
`else
    check("d_decerr", 64'(decerr), 64'h0);
    check("d_rdata", 64'(h_rdata[1]), 64'h0);
`endif
    tick(); hosts_idle(); settle();
    check("d_after", 64'(decerr), 64'h0);

    // granted host withdraws mid-wait
    tick();
    h_rd[0] = 1'b1; h_addr[0] = 32'h200; d_wait = 2'b01;
    settle();
    tick();
    h_rd[1] = 1'b1; h_addr[1] = 32'h300;
    settle();
    check("f_c1_addr", 64'(d_addr[0]), 64'h200);
    check("f_c1_wait", 64'(h_wait), 64'h3);
    tick();
    h_rd[0] = 1'b0;
    settle();
    check("f_drop_rd", 64'(d_rd[0]), 64'h0);
    check("f_drop_wait1", 64'(h_wait[1]), 64'h1);
    tick(); settle();
    check("f_gap_rd", 64'(d_rd[0]), 64'h0);
    tick();
    d_wait = '0;
    settle();
    check("f_h1_addr", 64'(d_addr[0]), 64'h300);
    check("f_h1_rd", 64'(d_rd[0]), 64'h1);
    check("f_h1_wait", 64'(h_wait[1]), 64'h0);
    tick(); hosts_idle(); settle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
